edge_delay_trigger: RTL and testbench

- Hardware counterpart of "@(edge) then #delay" procedural timing control.
- Watches an asynchronous level input, waits for a programmed edge type, counts a programmed number of clk cycles, then emits a one-cycle `fire` pulse.
- Sits upstream of counter/wait-style consumers, supplying them with timed trigger events.
- One-shot: re-armed explicitly per event.

---
 rtl/edge_trig_pkg.sv | 26 ++
 rtl/edge_delay_trigger_sync_edge_detect.sv | 32 +++
 rtl/edge_delay_trigger.sv | 131 +++++++++++++
 tb/tb_edge_delay_trigger.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/edge_trig_pkg.sv
// Shared encodings for the edge-then-delay trigger: edge-select codes, FSM states
// and the edge qualification helper.
package edge_trig_pkg;

   localparam logic [1:0] EDGE_POS = 2'b00;
   localparam logic [1:0] EDGE_NEG = 2'b01;
   localparam logic [1:0] EDGE_ANY = 2'b10;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_EDGE = 2'd1,
      COUNT     = 2'd2,
      FIRE      = 2'd3
   } state_t;

   // The reserved code 2'b11 behaves like EDGE_ANY.
   function automatic logic edge_hit(input logic [1:0] sel, input logic pos, input logic neg);
      case (sel)
         EDGE_POS: return pos;
         EDGE_NEG: return neg;
         EDGE_ANY: return pos | neg;
         default:  return pos | neg;
      endcase
   endfunction

endpackage

// File: rtl/edge_delay_trigger_sync_edge_detect.sv
// Synchronizer chain plus history flop for the monitored input; emits single-cycle
// pos/neg edge pulses in the clk domain.
module sync_edge_detect #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic sig_in,
   output logic pos,
   output logic neg
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   logic                   prev;

   assign s = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         prev   <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
         prev   <= s;
      end
   end

   assign pos = s & ~prev;
   assign neg = ~s & prev;

endmodule

// File: rtl/edge_delay_trigger.sv
// Waits for a programmed edge on an async input, counts a programmed delay, then
// pulses fire for one cycle. Option macro: EDGE_DELAY_TRIGGER_RETRIGGER_EN.
//
// state     | meaning
// IDLE      | disarmed, waiting for arm
// WAIT_EDGE | armed, watching for the latched edge type
// COUNT     | edge seen, cnt counting down to zero
// FIRE      | fire pulse cycle, returns to IDLE
module edge_delay_trigger
   import edge_trig_pkg::*;
#(
   parameter int DW          = 8,
   parameter int CW          = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          arm,
   input  logic          cancel,
   input  logic [1:0]    edge_sel,
   input  logic [DW-1:0] delay,
   input  logic          sig_in,
   output logic          busy,
   output logic          fire,
   output logic [CW-1:0] ev_cnt,
   output logic          missed
);

   state_t        state;
   logic [1:0]    sel_q;
   logic [DW-1:0] dly_q;
   logic [DW-1:0] cnt;
   logic          pos;
   logic          neg;
   logic          hit;

   sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk    (clk),
      .rst    (rst),
      .sig_in (sig_in),
      .pos    (pos),
      .neg    (neg)
   );

   assign hit  = edge_hit(sel_q, pos, neg);
   assign busy = (state != IDLE);

`ifdef EDGE_DELAY_TRIGGER_RETRIGGER_EN
   assign missed = 1'b0;
`else
   logic missed_q;
   assign missed = missed_q;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         sel_q  <= EDGE_POS;
         dly_q  <= '0;
         cnt    <= '0;
         ev_cnt <= '0;
         fire   <= 1'b0;
`ifndef EDGE_DELAY_TRIGGER_RETRIGGER_EN
         missed_q <= 1'b0;
`endif
      end else begin
         fire <= 1'b0;
         case (state)
            IDLE: begin
               if (arm && !cancel) begin
                  sel_q  <= edge_sel;
                  dly_q  <= delay;
                  ev_cnt <= '0;
`ifndef EDGE_DELAY_TRIGGER_RETRIGGER_EN
                  missed_q <= 1'b0;
`endif
                  state  <= WAIT_EDGE;
               end
            end
            WAIT_EDGE: begin
               if (cancel) begin
                  state <= IDLE;
               end else if (hit) begin
                  if (ev_cnt != '1) ev_cnt <= ev_cnt + 1'b1;
                  if (dly_q == '0) begin
                     fire  <= 1'b1;
                     state <= FIRE;
                  end else begin
                     cnt   <= dly_q - 1'b1;
                     state <= COUNT;
                  end
               end
            end
            COUNT: begin
               if (cancel) begin
                  state <= IDLE;
`ifdef EDGE_DELAY_TRIGGER_RETRIGGER_EN
               end else if (hit) begin
                  // A fresh edge restarts the delay from the latched value.
                  if (ev_cnt != '1) ev_cnt <= ev_cnt + 1'b1;
                  if (dly_q == '0) begin
                     fire  <= 1'b1;
                     state <= FIRE;
                  end else begin
                     cnt <= dly_q - 1'b1;
                  end
`endif
               end else begin
`ifndef EDGE_DELAY_TRIGGER_RETRIGGER_EN
                  if (hit) begin
                     if (ev_cnt != '1) ev_cnt <= ev_cnt + 1'b1;
                     missed_q <= 1'b1;
                  end
`endif
                  if (cnt == '0) begin
                     fire  <= 1'b1;
                     state <= FIRE;
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end
            end
            FIRE: begin
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_edge_delay_trigger.sv
// Scoreboard bench for edge_delay_trigger: expected fire cycles are queued when
// sig_in is driven and compared when fire pulses.
module tb_edge_delay_trigger;

   localparam int DW = 8;
   localparam int CW = 2;
   localparam int S  = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          arm;
   logic          cancel;
   logic [1:0]    edge_sel;
   logic [DW-1:0] delay;
   logic          sig_in;
   logic          busy;
   logic          fire;
   logic [CW-1:0] ev_cnt;
   logic          missed;

   int nchk = 0;
   int nerr = 0;
   int cyc  = 0;
   int sb[$];

   edge_delay_trigger #(.DW(DW), .CW(CW), .SYNC_STAGES(S)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .arm      (arm),
      .cancel   (cancel),
      .edge_sel (edge_sel),
      .delay    (delay),
      .sig_in   (sig_in),
      .busy     (busy),
      .fire     (fire),
      .ev_cnt   (ev_cnt),
      .missed   (missed)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // Fire monitor: every pulse must match the oldest expected cycle.
   always @(negedge clk) begin
      if (fire) begin
         if (sb.size() == 0) check("fire_unexpected", 1, 0);
         else begin
            int e;
            e = sb.pop_front();
            check("fire_cycle", cyc, e);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_arm(input logic [1:0] sel, input int d);
      edge_sel = sel;
      delay    = DW'(d);
      arm      = 1'b1;
      tick(1);
      arm      = 1'b0;
   endtask

   // Drive sig_in now and, if asked, queue the fire expected d cycles after the hit.
   task automatic drive_sig(input logic v, input bit expect_fire, input int d);
      sig_in = v;
      if (expect_fire) sb.push_back(cyc + S + 1 + d);
   endtask

   task automatic wait_idle(input string tag);
      bit done = 0;
      for (int i = 0; i < 300 && !done; i++) begin
         tick(1);
         if (!busy && sb.size() == 0) done = 1;
      end
      if (!done) check({tag, "_timeout"}, 0, 1);
   endtask

   initial begin
      int c;
      rst = 1'b1; arm = 1'b0; cancel = 1'b0; edge_sel = 2'b00; delay = '0; sig_in = 1'b0;
      tick(3);
      rst = 1'b0;
      tick(1);
      check("rst_busy", busy, 0);
      check("rst_fire", fire, 0);
      check("rst_ev", ev_cnt, 0);
      check("rst_missed", missed, 0);

      // Posedge, delay 5.
      do_arm(2'b00, 5);
      check("t1_busy_armed", busy, 1);
      drive_sig(1'b1, 1, 5);
      wait_idle("t1");
      check("t1_ev", ev_cnt, 1);
      check("t1_missed", missed, 0);

      // Negedge, delay 0: the rising edge must be ignored.
      sig_in = 1'b0;
      tick(6);
      do_arm(2'b01, 0);
      drive_sig(1'b1, 0, 0);
      tick(6);
      check("t2_busy_after_rise", busy, 1);
      check("t2_ev_after_rise", ev_cnt, 0);
      drive_sig(1'b0, 1, 0);
      wait_idle("t2");
      check("t2_ev", ev_cnt, 1);

      // Any edge, delay 10, second edge arrives during COUNT.
      tick(4);
      do_arm(2'b10, 10);
      c = cyc;
`ifdef EDGE_DELAY_TRIGGER_RETRIGGER_EN
      drive_sig(1'b1, 0, 10);
      tick(S + 3);
      drive_sig(1'b0, 1, 10);
      wait_idle("t3");
      check("t3_missed", missed, 0);
`else
      drive_sig(1'b1, 1, 10);
      tick(S + 3);
      drive_sig(1'b0, 0, 10);
      wait_idle("t3");
      check("t3_missed", missed, 1);
`endif
      check("t3_ev", ev_cnt, 2);

      // Cancel with a simultaneous arm during COUNT.
      tick(4);
      do_arm(2'b00, 20);
      drive_sig(1'b1, 0, 20);
      tick(S + 7);
      cancel = 1'b1; arm = 1'b1; delay = 8'd1;
      tick(1);
      cancel = 1'b0; arm = 1'b0;
      check("t4_busy_cancel", busy, 0);
      check("t4_ev_hold", ev_cnt, 1);
      tick(30);
      check("t4_busy_later", busy, 0);

      // Saturation: five edges during a long COUNT on a 2-bit counter.
      sig_in = 1'b0;
      tick(5);
      do_arm(2'b10, 200);
      for (int k = 0; k < 6; k++) begin
         sig_in = ~sig_in;
         tick(4);
      end
      check("t5_busy", busy, 1);
      check("t5_ev_sat", ev_cnt, 3);
`ifndef EDGE_DELAY_TRIGGER_RETRIGGER_EN
      check("t5_missed", missed, 1);
`endif
      cancel = 1'b1;
      tick(1);
      cancel = 1'b0;
      check("t5_ev_hold", ev_cnt, 3);

      // Async reset in the middle of COUNT.
      sig_in = 1'b0;
      tick(5);
      do_arm(2'b00, 50);
      drive_sig(1'b1, 0, 50);
      tick(S + 5);
      check("t6_ev_pre", ev_cnt, 1);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("t6_busy_rst", busy, 0);
      check("t6_fire_rst", fire, 0);
      check("t6_ev_rst", ev_cnt, 0);
      check("t6_missed_rst", missed, 0);
      @(negedge clk);
      rst = 1'b0;
      sig_in = 1'b0;
      tick(6);
      check("t6_idle_after", busy, 0);
      do_arm(2'b00, 3);
      drive_sig(1'b1, 1, 3);
      wait_idle("t6b");
      check("t6_ev_after", ev_cnt, 1);
      check("t6_missed_after", missed, 0);

      tick(3);
      check("sb_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
